// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot pixel streamer.
package mandelbrot_pkg;

    localparam int PIXEL_BITS = 4;
    localparam int BYTE_BITS  = 2 * PIXEL_BITS;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        BUSY
    } state_t;

    typedef struct packed {
        logic                 sof;
        logic                 eol;
        logic [BYTE_BITS-1:0] data;
    } entry_t;

endpackage

// File: rtl/mandelbrot_pixel_stream_if.sv
// Packed-pixel byte stream with valid/ready handshake and frame markers.
interface mandelbrot_pixel_stream_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic       out_eol;

    modport master (output out_data, out_valid, out_sof, out_eol, input out_ready);
    modport slave  (input out_data, out_valid, out_sof, out_eol, output out_ready);
endinterface

// File: rtl/mandelbrot_byte_fifo.sv
// Synchronous FIFO of {sof, eol, byte} entries; read data is zero while empty.
module mandelbrot_byte_fifo
    import mandelbrot_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  entry_t        wr_data,
    output entry_t        rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rd_data   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/mandelbrot_pixel_stream.sv
// Sequences the Mandelbrot core one pixel at a time in raster order and packs
// two 4-bit iteration counts per output byte.
//   state      | meaning
//   IDLE       | waiting for enable
//   ISSUE      | pulse core_run once the FIFO has a free entry
//   WAIT_START | core_run sent, waiting for core_running to rise
//   BUSY       | core iterating; capture on core_running falling edge
module mandelbrot_pixel_stream
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    output logic                      core_run,
    input  logic                      core_running,
    input  logic [PIXEL_BITS-1:0]     core_ctr,
    mandelbrot_pixel_stream_if.master out,
    output logic                      frame_done,
    output logic                      overflow_err
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                r_state;
    logic                  r_core_run;
    logic                  r_running_q;
    logic                  r_frame_done;
    logic                  r_overflow;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [PIXEL_BITS-1:0] r_hold;

    logic                  w_capture;
    logic                  w_last_x;
    logic                  w_last_y;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_room;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    entry_t                w_wr_entry;
    entry_t                w_rd_entry;

    assign w_capture  = (r_state == BUSY) && r_running_q && !core_running;
    assign w_last_x   = (r_x == XW'(WIDTH - 1));
    assign w_last_y   = (r_y == YW'(HEIGHT - 1));
    assign w_push     = w_capture && r_x[0];
    assign w_pop      = out.out_valid && out.out_ready;
    // A half-filled byte completes into the entry this check guarantees, so
    // only fully queued bytes need to be counted against the depth.
    assign w_room     = (w_count < CW'(FIFO_DEPTH));
    assign w_wr_entry = '{sof:  (r_x == XW'(1)) && (r_y == '0),
                          eol:  w_last_x,
                          data: {r_hold, core_ctr}};

    mandelbrot_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (w_wr_entry),
        .rd_data (w_rd_entry),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign out.out_valid = !w_empty;
    assign out.out_data  = w_rd_entry.data;
    assign out.out_sof   = w_rd_entry.sof;
    assign out.out_eol   = w_rd_entry.eol;
    assign core_run      = r_core_run;
    assign frame_done    = r_frame_done;
    assign overflow_err  = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_core_run   <= 1'b0;
            r_running_q  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_hold       <= '0;
        end else begin
            r_running_q  <= core_running;
            r_core_run   <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_push && w_full) r_overflow <= 1'b1;

            case (r_state)
                IDLE:       if (enable) r_state <= ISSUE;
                ISSUE:      if (w_room) begin
                                r_core_run <= 1'b1;
                                r_state    <= WAIT_START;
                            end
                WAIT_START: if (core_running) r_state <= BUSY;
                BUSY:       if (w_capture) r_state <= enable ? ISSUE : IDLE;
                default:    r_state <= IDLE;
            endcase

            if (w_capture) begin
                if (!r_x[0]) r_hold <= core_ctr;
                if (w_last_x) begin
                    r_x <= '0;
                    if (w_last_y) begin
                        r_y          <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_y <= r_y + YW'(1);
                    end
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_pixel_stream.sv
// Scoreboard bench: a behavioural core model queues expected bytes per capture,
// a monitor queues accepted bytes, and each scenario task compares the two.
module tb_mandelbrot_pixel_stream;
    import mandelbrot_pkg::*;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       core_run;
    logic       core_running;
    logic [3:0] core_ctr;
    logic       frame_done;
    logic       overflow_err;
    logic       ready_drv;
    logic       rnd_ready;
    logic       rand_en;

    mandelbrot_pixel_stream_if bus ();
    assign bus.out_ready = rand_en ? rnd_ready : ready_drv;

    mandelbrot_pixel_stream #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .core_run     (core_run),
        .core_running (core_running),
        .core_ctr     (core_ctr),
        .out          (bus),
        .frame_done   (frame_done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    entry_t     exp_q[$];
    entry_t     got_q[$];
    logic [3:0] ctr_q[$];
    int cap_cnt, run_cnt, run_double, fd_cnt, fd_at, stall_viol;
    int vectors, miscompares, timeouts;

    // Core model: starts on core_run, runs 1..3 cycles, drops running with a result.
    int         busy;
    int         mx, my;
    logic [3:0] mhold;
    always @(negedge clk) begin
        logic [3:0] v;
        if (rst) begin
            core_running = 1'b0;
            core_ctr     = 4'h0;
            busy = 0; mx = 0; my = 0; mhold = 4'h0;
        end else begin
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    v = (ctr_q.size() > 0) ? ctr_q.pop_front() : 4'($urandom_range(0, 15));
                    core_running = 1'b0;
                    core_ctr     = v;
                    cap_cnt++;
                    if (mx % 2 == 0) mhold = v;
                    else exp_q.push_back('{sof: (mx == 1 && my == 0), eol: (mx == W - 1), data: {mhold, v}});
                    if (mx == W - 1) begin
                        mx = 0;
                        my = (my == H - 1) ? 0 : my + 1;
                    end else begin
                        mx++;
                    end
                end
            end
            if (core_run) begin
                core_running = 1'b1;
                busy = $urandom_range(1, 3);
            end
        end
    end

    // Monitor: accepted bytes, run pulses, frame_done pulses, stall stability.
    logic   prev_stall, prev_run;
    entry_t prev_ent;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_run   = 1'b0;
        end else begin
            if (prev_stall && (!bus.out_valid || {bus.out_sof, bus.out_eol, bus.out_data} != prev_ent))
                stall_viol++;
            if (bus.out_valid && bus.out_ready)
                got_q.push_back('{sof: bus.out_sof, eol: bus.out_eol, data: bus.out_data});
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_ent   = '{sof: bus.out_sof, eol: bus.out_eol, data: bus.out_data};
            if (core_run) begin
                run_cnt++;
                if (prev_run) run_double++;
            end
            prev_run = core_run;
            if (frame_done) begin
                fd_cnt++;
                fd_at = cap_cnt;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cap(input int target);
        int n = 0;
        while (cap_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        if (cap_cnt < target) timeouts++;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; ready_drv = 1'b1; rand_en = 1'b0;
        repeat (3) tick();
        exp_q.delete(); got_q.delete(); ctr_q.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int rb;
        rst = 1'b1; enable = 1'b1; ready_drv = 1'b1; rand_en = 1'b0;
        repeat (3) tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", bus.out_data); end
        vectors++; if (core_run !== 1'b0) begin miscompares++; $display("FAIL reset_run: got %b want 0", core_run); end
        vectors++; if (dut.r_state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want IDLE", dut.r_state); end
        enable = 1'b0;
        exp_q.delete(); got_q.delete();
        rst = 1'b0;
        rb = run_cnt;
        repeat (6) tick();
        vectors++; if (run_cnt - rb !== 0) begin miscompares++; $display("FAIL idle_no_run: got %0d pulses want 0", run_cnt - rb); end
        vectors++; if (dut.r_state !== IDLE) begin miscompares++; $display("FAIL idle_hold: got %0d want IDLE", dut.r_state); end
        vectors++; if ({frame_done, overflow_err, bus.out_sof, bus.out_eol} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_flags: got %b want 0000", {frame_done, overflow_err, bus.out_sof, bus.out_eol}); end
    endtask

    task automatic test_single_byte();
        int base, rb, n, to;
        logic prev_v;
        entry_t g, e;
        do_reset();
        to = timeouts;
        ctr_q.push_back(4'h3); ctr_q.push_back(4'hA);
        ready_drv = 1'b0;
        base = cap_cnt; rb = run_cnt;
        enable = 1'b1;
        n = 0;
        while (run_cnt < rb + 2 && n < 200) begin tick(); n++; end
        if (run_cnt < rb + 2) timeouts++;
        enable = 1'b0;
        n = 0; prev_v = 1'b0;
        while (cap_cnt < base + 2 && n < 200) begin prev_v = bus.out_valid; tick(); n++; end
        vectors++; if (prev_v !== 1'b0) begin miscompares++; $display("FAIL early_valid: got %b want 0", prev_v); end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL latency_valid: got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_data !== 8'h3A) begin miscompares++; $display("FAIL byte_3A: got %h want 3a", bus.out_data); end
        vectors++; if ({bus.out_sof, bus.out_eol} !== 2'b10) begin miscompares++; $display("FAIL sof_eol: got %b want 10", {bus.out_sof, bus.out_eol}); end
        repeat (5) tick();
        vectors++; if (run_cnt - rb !== 2) begin miscompares++; $display("FAIL run_pulses: got %0d want 2", run_cnt - rb); end
        vectors++; if (run_double !== 0) begin miscompares++; $display("FAIL run_width: got %0d long pulses want 0", run_double); end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL held_valid: got %b want 1", bus.out_valid); end
        ready_drv = 1'b1;
        repeat (2) tick();
        vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            vectors++; if (g !== e) begin miscompares++; $display("FAIL single_sb: got %h want %h", g, e); end
        end
        vectors++; if (timeouts !== to) begin miscompares++; $display("FAIL single_timeout: got %0d timeouts want %0d", timeouts, to); end
    endtask

    task automatic test_frame();
        int base, fb, to;
        logic [3:0] eol_pat, sof_pat;
        entry_t g, e;
        eol_pat = 4'b1010; sof_pat = 4'b0001;
        do_reset();
        to = timeouts; base = cap_cnt; fb = fd_cnt;
        enable = 1'b1;
        wait_cap(base + 7);
        enable = 1'b0;
        wait_cap(base + 8);
        repeat (6) tick();
        vectors++; if (fd_cnt - fb !== 1) begin miscompares++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt - fb); end
        vectors++; if (fd_at !== base + 8) begin miscompares++; $display("FAIL frame_done_at: got capture %0d want 8", fd_at - base); end
        vectors++; if (got_q.size() !== 4) begin miscompares++; $display("FAIL frame_bytes: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                vectors++; if (g !== e) begin miscompares++; $display("FAIL frame_sb[%0d]: got %h want %h", i, g, e); end
                vectors++; if ({g.sof, g.eol} !== {sof_pat[i], eol_pat[i]}) begin
                    miscompares++; $display("FAIL frame_marks[%0d]: got %b want %b", i, {g.sof, g.eol}, {sof_pat[i], eol_pat[i]}); end
            end
        end
        enable = 1'b1;
        wait_cap(base + 9);
        enable = 1'b0;
        wait_cap(base + 10);
        repeat (6) tick();
        vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL frame2_bytes: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            vectors++; if (g.sof !== 1'b1) begin miscompares++; $display("FAIL frame2_sof: got %b want 1", g.sof); end
            vectors++; if (g !== e) begin miscompares++; $display("FAIL frame2_sb: got %h want %h", g, e); end
        end
        vectors++; if (timeouts !== to) begin miscompares++; $display("FAIL frame_timeout: got %0d timeouts want %0d", timeouts, to); end
    endtask

    task automatic test_backpressure();
        int base, rb, to, ng;
        entry_t g, e;
        do_reset();
        to = timeouts; base = cap_cnt; rb = run_cnt;
        ready_drv = 1'b0;
        enable = 1'b1;
        repeat (150) tick();
        vectors++; if (cap_cnt - base !== 8) begin miscompares++; $display("FAIL bp_captures: got %0d want 8", cap_cnt - base); end
        vectors++; if (run_cnt - rb !== 8) begin miscompares++; $display("FAIL bp_runs: got %0d want 8", run_cnt - rb); end
        vectors++; if (dut.r_state !== ISSUE) begin miscompares++; $display("FAIL bp_hold_issue: got %0d want ISSUE", dut.r_state); end
        ready_drv = 1'b1;
        wait_cap(base + 11);
        enable = 1'b0;
        wait_cap(base + 12);
        repeat (12) tick();
        vectors++; if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL bp_overflow: got %b want 0", overflow_err); end
        vectors++; if (got_q.size() !== 6) begin miscompares++; $display("FAIL bp_bytes: got %0d want 6", got_q.size()); end
        ng = got_q.size();
        for (int i = 0; i < ng; i++) begin
            if (exp_q.size() > 0) begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                vectors++; if (g !== e) begin miscompares++; $display("FAIL bp_sb[%0d]: got %h want %h", i, g, e); end
            end
        end
        vectors++; if (timeouts !== to) begin miscompares++; $display("FAIL bp_timeout: got %0d timeouts want %0d", timeouts, to); end
    endtask

    task automatic test_enable_drop();
        int base, rb, to, n;
        entry_t g, e;
        do_reset();
        to = timeouts; base = cap_cnt; rb = run_cnt;
        enable = 1'b1;
        n = 0;
        while (dut.r_state !== BUSY && n < 200) begin tick(); n++; end
        if (dut.r_state !== BUSY) timeouts++;
        enable = 1'b0;
        repeat (20) tick();
        vectors++; if (cap_cnt - base !== 1) begin miscompares++; $display("FAIL drop_captured: got %0d want 1", cap_cnt - base); end
        vectors++; if (run_cnt - rb !== 1) begin miscompares++; $display("FAIL drop_runs: got %0d want 1", run_cnt - rb); end
        vectors++; if (dut.r_x !== 2'd1) begin miscompares++; $display("FAIL drop_x: got %0d want 1", dut.r_x); end
        vectors++; if (dut.r_state !== IDLE) begin miscompares++; $display("FAIL drop_idle: got %0d want IDLE", dut.r_state); end
        enable = 1'b1;
        wait_cap(base + 3);
        enable = 1'b0;
        wait_cap(base + 4);
        repeat (6) tick();
        vectors++; if (got_q.size() !== 2) begin miscompares++; $display("FAIL drop_bytes: got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            if (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                vectors++; if (g !== e) begin miscompares++; $display("FAIL drop_sb[%0d]: got %h want %h", i, g, e); end
            end
        end
        vectors++; if (timeouts !== to) begin miscompares++; $display("FAIL drop_timeout: got %0d timeouts want %0d", timeouts, to); end
    endtask

    task automatic test_reset_mid();
        int base, to;
        do_reset();
        to = timeouts; base = cap_cnt;
        ready_drv = 1'b0;
        enable = 1'b1;
        wait_cap(base + 4);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_queued: got %b want 1", bus.out_valid); end
        rst = 1'b1;
        enable = 1'b0;
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b want 0", bus.out_valid); end
        vectors++; if ({dut.r_x, dut.r_y} !== 3'b000) begin miscompares++; $display("FAIL mid_xy: got x=%0d y=%0d want 0 0", dut.r_x, dut.r_y); end
        vectors++; if (dut.r_state !== IDLE) begin miscompares++; $display("FAIL mid_state: got %0d want IDLE", dut.r_state); end
        rst = 1'b0;
        exp_q.delete(); got_q.delete();
        ready_drv = 1'b1;
        repeat (4) tick();
        vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL mid_flushed: got %0d bytes want 0", got_q.size()); end
        vectors++; if (timeouts !== to) begin miscompares++; $display("FAIL mid_timeout: got %0d timeouts want %0d", timeouts, to); end
    endtask

    task automatic test_random_ready();
        int base, fb, sb, to, ng;
        entry_t g, e;
        do_reset();
        to = timeouts; base = cap_cnt; fb = fd_cnt; sb = stall_viol;
        rand_en = 1'b1;
        enable = 1'b1;
        wait_cap(base + 23);
        enable = 1'b0;
        wait_cap(base + 24);
        repeat (4) tick();
        rand_en = 1'b0;
        ready_drv = 1'b1;
        repeat (10) tick();
        vectors++; if (got_q.size() !== 12) begin miscompares++; $display("FAIL rnd_bytes: got %0d want 12", got_q.size()); end
        ng = got_q.size();
        for (int i = 0; i < ng; i++) begin
            if (exp_q.size() > 0) begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                vectors++; if (g !== e) begin miscompares++; $display("FAIL rnd_sb[%0d]: got %h want %h", i, g, e); end
            end
        end
        vectors++; if (stall_viol - sb !== 0) begin miscompares++; $display("FAIL rnd_stable: got %0d changes while stalled want 0", stall_viol - sb); end
        vectors++; if (fd_cnt - fb !== 3) begin miscompares++; $display("FAIL rnd_frames: got %0d want 3", fd_cnt - fb); end
        vectors++; if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL rnd_overflow: got %b want 0", overflow_err); end
        vectors++; if (run_double !== 0) begin miscompares++; $display("FAIL rnd_run_width: got %0d want 0", run_double); end
        vectors++; if (timeouts !== to) begin miscompares++; $display("FAIL rnd_timeout: got %0d timeouts want %0d", timeouts, to); end
    endtask

    initial begin
        vectors = 0; miscompares = 0; timeouts = 0;
        rst = 1'b1; enable = 1'b0; ready_drv = 1'b1; rand_en = 1'b0;
        test_reset();
        test_single_byte();
        test_frame();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
        test_random_ready();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
